// File: rtl/comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// Result encoding is one-hot {gt, eq, lt}; Y_NONE means no result yet.
`timescale 1ns/1ps
package comparator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int Y_GT = 2;
  localparam int Y_EQ = 1;
  localparam int Y_LT = 0;

  localparam logic [2:0] Y_NONE = 3'b000;
  localparam logic [2:0] Y_GT_V = 3'b100;
  localparam logic [2:0] Y_EQ_V = 3'b010;
  localparam logic [2:0] Y_LT_V = 3'b001;

  // Build the one-hot result; gt wins if both are ever asserted.
  function automatic logic [2:0] encode_result(input logic gt, input logic lt);
    logic [2:0] r;
    r       = Y_NONE;
    r[Y_GT] = gt;
    r[Y_LT] = lt & ~gt;
    r[Y_EQ] = ~gt & ~lt;
    return r;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
`timescale 1ns/1ps
module comparator_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/comparator_serial.sv
// Multi-cycle magnitude comparator: compares WIDTH-bit operands CHUNK bits
// per clock, MSB chunk first, with a start/busy/done handshake.
// Signed operands are mapped to offset binary at capture (MSB inverted), so
// every chunk compare afterwards is unsigned.
// Optional build macro COMPARATOR_SERIAL_EARLY_TERM_EN: finish on the first
// differing chunk instead of always walking all NCHUNK chunks.
//
// state | meaning
// IDLE  | waiting for start; y holds the last result
// RUN   | comparing chunk idx of the captured operands
`timescale 1ns/1ps
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [2:0]       y
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx;
  logic               hit;
  logic               hit_gt;

  logic               c_gt;
  logic               c_lt;
  logic               res_gt;
  logic               res_lt;
  logic               finish;

  // Captured operands are shifted left each cycle, so the chunk under
  // compare is always the top CHUNK bits.
  comparator_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (a_q[WIDTH-1 -: CHUNK]),
    .b  (b_q[WIDTH-1 -: CHUNK]),
    .gt (c_gt),
    .lt (c_lt)
  );

  // Once a higher chunk has differed, its verdict is sticky.
  always_comb begin
    res_gt = hit ? hit_gt  : c_gt;
    res_lt = hit ? ~hit_gt : c_lt;
`ifdef COMPARATOR_SERIAL_EARLY_TERM_EN
    finish = (idx == '0) | c_gt | c_lt;
`else
    finish = (idx == '0);
`endif
  end

  // Handshake FSM with capture, chunk walk and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      hit    <= 1'b0;
      hit_gt <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= Y_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a ^ (signed_mode ? MSB_MASK : '0);
            b_q    <= b ^ (signed_mode ? MSB_MASK : '0);
            idx    <= IDX_LAST;
            hit    <= 1'b0;
            hit_gt <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (finish) begin
            y     <= encode_result(res_gt, res_lt);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - 1'b1;
            a_q <= a_q << CHUNK;
            b_q <= b_q << CHUNK;
            if (!hit && (c_gt || c_lt)) begin
              hit    <= 1'b1;
              hit_gt <= c_gt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_serial.sv
// Directed bench for comparator_serial (16/4 instance plus an 8/8 instance).
`timescale 1ns/1ps
module tb_comparator_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [2:0]  y;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        sm8;
  logic        busy8;
  logic        done8;
  logic [2:0]  y8;

  int tests = 0;
  int fails = 0;

`ifdef COMPARATOR_SERIAL_EARLY_TERM_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 4;
`endif

  always #5 clk = ~clk;

  comparator_serial #(.WIDTH(16), .CHUNK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .y           (y)
  );

  comparator_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .a           (a8),
    .b           (b8),
    .signed_mode (sm8),
    .busy        (busy8),
    .done        (done8),
    .y           (y8)
  );

  // Issue one op on the 16-bit DUT; lat = cycles from accept to done.
  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic sm,
                        output logic [2:0] ry, output int lat, output int bcnt);
    @(negedge clk);
    a = oa; b = ob; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~oa; b = ~ob; signed_mode = ~sm;
    lat = 0; bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bcnt++;
      if (done) break;
      @(negedge clk);
      lat++;
    end
    ry = y;
  endtask

  task automatic check_op(input string name, input logic [15:0] oa, input logic [15:0] ob,
                          input logic sm, input logic [2:0] ey, input int elat);
    logic [2:0] ry;
    int lat, bcnt;
    run_op(oa, ob, sm, ry, lat, bcnt);
    tests++;
    if (ry !== ey) begin
      fails++;
      $display("FAIL %s y: got %b expected %b", name, ry, ey);
    end
    tests++;
    if (lat !== elat) begin
      fails++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, y} !== 5'b0) begin
      fails++;
      $display("FAIL reset16: got busy=%b done=%b y=%b expected 0 0 000", busy, done, y);
    end
    tests++;
    if ({busy8, done8, y8} !== 5'b0) begin
      fails++;
      $display("FAIL reset8: got busy=%b done=%b y=%b expected 0 0 000", busy8, done8, y8);
    end
    rst = 1'b0;
  endtask

  task automatic test_equal();
    logic [2:0] ry;
    int lat, bcnt;
    run_op(16'h1234, 16'h1234, 1'b0, ry, lat, bcnt);
    tests++;
    if (ry !== 3'b010) begin
      fails++;
      $display("FAIL equal y: got %b expected 010", ry);
    end
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL equal latency: got %0d expected 4", lat);
    end
    tests++;
    if (bcnt !== 4) begin
      fails++;
      $display("FAIL equal busy_cycles: got %0d expected 4", bcnt);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL equal busy_at_done: got %b expected 0", busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || y !== 3'b010) begin
      fails++;
      $display("FAIL equal hold: got done=%b y=%b expected done=0 y=010", done, y);
    end
  endtask

  task automatic test_signed();
    check_op("unsigned_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b100, FAST);
    check_op("signed_8000_7fff",   16'h8000, 16'h7FFF, 1'b1, 3'b001, FAST);
    check_op("signed_ffff_0001",   16'hFFFF, 16'h0001, 1'b1, 3'b001, FAST);
  endtask

  task automatic test_chunk_position();
    check_op("chunk0_diff", 16'h00F1, 16'h00F2, 1'b0, 3'b001, 4);
    check_op("chunk3_diff", 16'hA000, 16'h9FFF, 1'b0, 3'b100, FAST);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea [3];
    logic [15:0] eb [3];
    logic [2:0]  ey [3];
    int          el [3];
    int          n;
    ea[0] = 16'hFFFF; eb[0] = 16'h0000; ey[0] = 3'b100; el[0] = FAST;
    ea[1] = 16'h0000; eb[1] = 16'hFFFF; ey[1] = 3'b001; el[1] = FAST;
    ea[2] = 16'h5555; eb[2] = 16'h5555; ey[2] = 3'b010; el[2] = 4;
    @(negedge clk);
    a = ea[0]; b = eb[0]; signed_mode = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        n++;
        if (done) break;
      end
      tests++;
      if (y !== ey[i]) begin
        fails++;
        $display("FAIL b2b op%0d y: got %b expected %b", i, y, ey[i]);
      end
      tests++;
      if (n !== el[i] + 1) begin
        fails++;
        $display("FAIL b2b op%0d spacing: got %0d expected %0d", i, n, el[i] + 1);
      end
      if (i < 2) begin
        a = ea[i+1]; b = eb[i+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || y !== 3'b010) begin
      fails++;
      $display("FAIL b2b idle_after: got busy=%b y=%b expected busy=0 y=010", busy, y);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    int extra;
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    @(negedge clk);
    n++;
    start = 1'b1; a = 16'hFFFF; b = 16'h0000;
    @(negedge clk);
    n++;
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 4 || y !== 3'b010) begin
      fails++;
      $display("FAIL start_ignored result: got lat=%0d y=%b expected lat=4 y=010", n, y);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL start_ignored no_queue: got %0d busy/done cycles expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, y} !== 5'b0) begin
      fails++;
      $display("FAIL midrun_reset: got busy=%b done=%b y=%b expected 0 0 000", busy, done, y);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL midrun_reset no_done: got %0d done pulses expected 0", seen);
    end
    check_op("after_reset", 16'h1234, 16'h1235, 1'b0, 3'b001, 4);
  endtask

  task automatic test_width8();
    int n;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h01; sm8 = (k == 0); start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      tests++;
      if (busy8 !== 1'b1) begin
        fails++;
        $display("FAIL w8 busy: got %b expected 1", busy8);
      end
      n = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        n++;
        if (done8) break;
      end
      tests++;
      if (n !== 1 || y8 !== ((k == 0) ? 3'b001 : 3'b100)) begin
        fails++;
        $display("FAIL w8 op%0d: got lat=%0d y=%b expected lat=1 y=%b", k, n, y8,
                 (k == 0) ? 3'b001 : 3'b100);
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_signed();
    test_chunk_position();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
